gf_syndrome_counter: RTL and testbench



---
 rtl/gf_syndrome_counter_if.sv | 23 ++
 rtl/gf_syndrome_counter.sv | 116 +++++++++++
 tb/tb_gf_syndrome_counter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gf_syndrome_counter_if.sv
// gf_syndrome_counter_if: framed codeword input and syndrome result bundle for the BCH syndrome stage
// Parameters: m (field order), pT (correction capability), pDAT_W (input bits per cycle)
// Signals:
//   isop, ieop, ival, idat : framed input word (driven by master)
//   oval                   : one-cycle "syndromes ready" strobe (driven by slave)
//   osyndrome              : S_1..S_2pT, S_1 in the most significant slot
//   olen_err, onz          : frame length mismatch / some syndrome non-zero, valid with oval
interface gf_syndrome_counter_if #(
    parameter int m = 4,
    parameter int pT = 2,
    parameter int pDAT_W = 4
);
    logic isop;
    logic ieop;
    logic ival;
    logic [pDAT_W-1:0] idat;
    logic oval;
    logic [1:2*pT][m-1:0] osyndrome;
    logic olen_err;
    logic onz;
    modport master (output isop, ieop, ival, idat, input oval, osyndrome, olen_err, onz);
    modport slave (input isop, ieop, ival, idat, output oval, osyndrome, olen_err, onz);
endinterface

// File: rtl/gf_syndrome_counter.sv
// gf_syndrome_counter: streaming 2*pT syndrome calculator over GF(2^m) for framed BCH codewords
// Ports:
//   iclk     : clock
//   ireset_n : synchronous active-low reset
//   iclkena  : clock enable, all state frozen when low
//   bus      : gf_syndrome_counter_if.slave (isop/ieop/ival/idat in, oval/osyndrome/olen_err/onz out)
// Optional feature macro GF_SYNDROME_COUNTER_NZ_EN: registered non-zero flag onz; when undefined onz is 0.
module gf_syndrome_counter #(
    parameter int m = 4,
    parameter int irrpol = 19,
    parameter int pN = 15,
    parameter int pT = 2,
    parameter int pDAT_W = 4
) (
    input  logic iclk,
    input  logic ireset_n,
    input  logic iclkena,
    gf_syndrome_counter_if.slave bus
);
    localparam int pWORDS = (pN + pDAT_W - 1) / pDAT_W;
    localparam int pTAIL = pN - (pWORDS - 1) * pDAT_W;
    localparam int cw = $clog2(pWORDS + 2);
    localparam logic [m-1:0] poly = m'(irrpol);

    // multiply by alpha: shift and fold the x^m term back through the primitive polynomial
    function automatic logic [m-1:0] xtime(input logic [m-1:0] t);
        return {t[m-2:0], 1'b0} ^ (t[m-1] ? poly : '0);
    endfunction

    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] p;
        logic [m-1:0] t;
        p = '0;
        t = a;
        for (int k = 0; k < m; k++) begin
            p = p ^ (b[k] ? t : '0);
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [1:2*pT][m-1:0] alpha_tab();
        logic [1:2*pT][m-1:0] r;
        logic [m-1:0] p;
        r = '0;
        p = {{(m-1){1'b0}}, 1'b1};
        for (int i = 1; i <= 2 * pT; i++) begin
            p = xtime(p);
            r[i] = p;
        end
        return r;
    endfunction

    localparam logic [1:2*pT][m-1:0] alpha = alpha_tab();

    logic inframe;
    logic [cw-1:0] wcnt;
    logic [cw-1:0] cnt;
    logic [1:2*pT][m-1:0] acc;
    logic [1:2*pT][m-1:0] nxt;
    logic acc_en;
    logic fire;

    // words outside a frame (before isop or after ieop) are dropped entirely
    assign acc_en = iclkena & bus.ival & (bus.isop | inframe);
    assign fire = acc_en & bus.ieop;
    assign cnt = bus.isop ? cw'(1) : wcnt + cw'(1);

    // Horner over the word, LSB first; on ieop the bits past the tail are skipped, not multiplied
    always_comb begin
        nxt = '0;
        for (int i = 1; i <= 2 * pT; i++) begin
            nxt[i] = bus.isop ? '0 : acc[i];
            for (int b = 0; b < pDAT_W; b++)
                if (!bus.ieop || b < pTAIL)
                    nxt[i] = gf_mul(nxt[i], alpha[i]) ^ {{(m-1){1'b0}}, bus.idat[b]};
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            inframe <= 1'b0;
            wcnt <= '0;
            acc <= '0;
        end else if (acc_en) begin
            inframe <= !bus.ieop;
            wcnt <= (!bus.isop && wcnt == cw'(pWORDS)) ? wcnt : cnt;
            acc <= nxt;
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            bus.oval <= 1'b0;
            bus.osyndrome <= '0;
            bus.olen_err <= 1'b0;
        end else if (iclkena) begin
            bus.oval <= fire;
            if (fire) begin
                bus.osyndrome <= nxt;
                bus.olen_err <= cnt != cw'(pWORDS);
            end
        end
    end

`ifdef GF_SYNDROME_COUNTER_NZ_EN
    always_ff @(posedge iclk) begin
        if (!ireset_n)
            bus.onz <= 1'b0;
        else if (fire)
            bus.onz <= |nxt;
    end
`else
    assign bus.onz = 1'b0;
`endif
endmodule

// File: tb/tb_gf_syndrome_counter.sv
// tb_gf_syndrome_counter: directed self-checking bench for gf_syndrome_counter (m=4, pN=15, pT=2, pDAT_W=4)
module tb_gf_syndrome_counter;
    logic iclk;
    logic ireset_n;
    logic iclkena;
    int passed;
    int failed;
    int total;

`ifdef GF_SYNDROME_COUNTER_NZ_EN
    localparam logic nz = 1'b1;
`else
    localparam logic nz = 1'b0;
`endif

    gf_syndrome_counter_if #(.m(4), .pT(2), .pDAT_W(4)) bus ();

    gf_syndrome_counter #(.m(4), .irrpol(19), .pN(15), .pT(2), .pDAT_W(4)) dut (
        .iclk(iclk),
        .ireset_n(ireset_n),
        .iclkena(iclkena),
        .bus(bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic sop, input logic eop, input logic val, input logic [3:0] dat);
        bus.isop = sop;
        bus.ieop = eop;
        bus.ival = val;
        bus.idat = dat;
        @(posedge iclk);
        #1;
    endtask

    task automatic frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        word(1'b1, 1'b0, 1'b1, d0);
        word(1'b0, 1'b0, 1'b1, d1);
        word(1'b0, 1'b0, 1'b1, d2);
        word(1'b0, 1'b1, 1'b1, d3);
    endtask

    task automatic result(input string tag, input logic [15:0] s, input logic err, input logic z);
        chk({tag, ".oval"}, 32'(bus.oval), 32'd1);
        chk({tag, ".syn"}, 32'(bus.osyndrome), 32'(s));
        chk({tag, ".len_err"}, 32'(bus.olen_err), 32'(err));
        chk({tag, ".onz"}, 32'(bus.onz), 32'(z));
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total = 0;
        ireset_n = 1'b0;
        iclkena = 1'b1;
        word(1'b0, 1'b0, 1'b0, 4'h0);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        chk("rst.oval", 32'(bus.oval), 32'd0);
        chk("rst.syn", 32'(bus.osyndrome), 32'd0);
        chk("rst.len_err", 32'(bus.olen_err), 32'd0);
        chk("rst.onz", 32'(bus.onz), 32'd0);
        ireset_n = 1'b1;
        word(1'b0, 1'b0, 1'b0, 4'h0);
        frame(4'h0, 4'h0, 4'h0, 4'h0);
        result("zero", 16'h0000, 1'b0, 1'b0);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        chk("zero.strobe_end", 32'(bus.oval), 32'd0);
        frame(4'h0, 4'h0, 4'h0, 4'hC);
        result("x0", 16'h1111, 1'b0, nz);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        frame(4'h1, 4'h0, 4'h0, 4'h0);
        result("x14", 16'h9DFE, 1'b0, nz);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        chk("x14.held", 32'(bus.osyndrome), 32'h9DFE);
        word(1'b1, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b1, 1'b1, 4'h0);
        result("short", 16'h0000, 1'b1, 1'b0);
        frame(4'h0, 4'h0, 4'h0, 4'h0);
        result("after_short", 16'h0000, 1'b0, 1'b0);
        word(1'b1, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b1, 1'b1, 4'h0);
        result("long", 16'h0000, 1'b1, 1'b0);
        word(1'b1, 1'b0, 1'b1, 4'hF);
        chk("restart.a0", 32'(bus.oval), 32'd0);
        word(1'b0, 1'b0, 1'b1, 4'hF);
        chk("restart.a1", 32'(bus.oval), 32'd0);
        word(1'b1, 1'b0, 1'b1, 4'h0);
        chk("restart.b0", 32'(bus.oval), 32'd0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        chk("restart.b2", 32'(bus.oval), 32'd0);
        word(1'b0, 1'b1, 1'b1, 4'h0);
        result("restart", 16'h0000, 1'b0, 1'b0);
        frame(4'h1, 4'h0, 4'h0, 4'h0);
        result("b2b.first", 16'h9DFE, 1'b0, nz);
        word(1'b1, 1'b0, 1'b1, 4'h0);
        chk("b2b.gap", 32'(bus.oval), 32'd0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b1, 1'b1, 4'hC);
        result("b2b.second", 16'h1111, 1'b0, nz);
        word(1'b1, 1'b1, 1'b1, 4'h1);
        result("single", 16'h43C5, 1'b1, nz);
        word(1'b0, 1'b0, 1'b1, 4'hF);
        word(1'b0, 1'b1, 1'b1, 4'hF);
        chk("gated.oval", 32'(bus.oval), 32'd0);
        chk("gated.syn", 32'(bus.osyndrome), 32'h43C5);
        word(1'b1, 1'b0, 1'b1, 4'h1);
        word(1'b0, 1'b0, 1'b0, 4'hF);
        word(1'b0, 1'b0, 1'b0, 4'hF);
        word(1'b0, 1'b0, 1'b0, 4'hF);
        iclkena = 1'b0;
        word(1'b1, 1'b1, 1'b1, 4'hF);
        word(1'b1, 1'b1, 1'b1, 4'hF);
        word(1'b1, 1'b1, 1'b1, 4'hF);
        chk("stall.mid_oval", 32'(bus.oval), 32'd0);
        iclkena = 1'b1;
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b1, 1'b1, 4'h0);
        result("stall", 16'h9DFE, 1'b0, nz);
        iclkena = 1'b0;
        word(1'b0, 1'b0, 1'b0, 4'h0);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        chk("stall.oval_held", 32'(bus.oval), 32'd1);
        iclkena = 1'b1;
        word(1'b0, 1'b0, 1'b0, 4'h0);
        chk("stall.oval_drop", 32'(bus.oval), 32'd0);
        chk("stall.syn_held", 32'(bus.osyndrome), 32'h9DFE);
        word(1'b1, 1'b0, 1'b1, 4'h1);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        ireset_n = 1'b0;
        word(1'b0, 1'b0, 1'b0, 4'h0);
        ireset_n = 1'b1;
        chk("midrst.syn", 32'(bus.osyndrome), 32'd0);
        word(1'b0, 1'b0, 1'b1, 4'h0);
        word(1'b0, 1'b1, 1'b1, 4'h0);
        chk("midrst.no_strobe", 32'(bus.oval), 32'd0);
        word(1'b0, 1'b0, 1'b0, 4'h0);
        chk("midrst.no_strobe2", 32'(bus.oval), 32'd0);
        frame(4'h1, 4'h0, 4'h0, 4'h0);
        result("post_rst", 16'h9DFE, 1'b0, nz);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
